// File: rtl/spi_slave_if.sv
// SPI responder bus: serial pins towards the master plus the parallel
// tx/rx side towards the local host logic.
interface spi_slave_if #(
  parameter int reg_width = 16,
  parameter int cnt_w     = 5
);
  logic                 spi_clk;
  logic                 cs;
  logic                 mosi;
  logic                 miso;
  logic [reg_width-1:0] tx_data;
  logic                 tx_load;
  logic                 tx_ready;
  logic [reg_width-1:0] data_out;
  logic                 rx_valid;
  logic [cnt_w-1:0]     rx_bits;

  // Driver side: SPI master pins and the host that feeds tx / consumes rx.
  modport master (
    output spi_clk, cs, mosi, tx_data, tx_load,
    input  miso, tx_ready, data_out, rx_valid, rx_bits
  );

  // Responder side: the spi_slave block itself.
  modport slave (
    input  spi_clk, cs, mosi, tx_data, tx_load,
    output miso, tx_ready, data_out, rx_valid, rx_bits
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first. All SPI pins are oversampled in the
// sys_clk domain; words are shifted out of tx_shift on miso while mosi is
// captured into rx_shift. Full and partial words are reported on data_out.
//
// state  | meaning
// -------+------------------------------------------------------------
// WAIT   | after reset; ignore any frame in flight until cs is seen high
// IDLE   | cs high, waiting for the falling edge that starts a frame
// ACTIVE | frame in progress; shift on spi_clk edges until cs rises
module spi_slave #(
  parameter int reg_width   = 16,
  parameter int sync_stages = 2,
  parameter int cnt_w       = 5
) (
  input  logic       sys_clk,
  input  logic       rst,
  spi_slave_if.slave bus
);

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    IDLE   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [cnt_w-1:0] last_cnt = cnt_w'(reg_width - 1);
  localparam logic [cnt_w-1:0] full_cnt = cnt_w'(reg_width);

  state_t state, state_nxt;

  logic [sync_stages-1:0] sclk_pipe;
  logic [sync_stages-1:0] cs_pipe;
  logic [sync_stages-1:0] mosi_pipe;
  logic                   sclk_d;
  logic                   cs_d;

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_rise;
  logic cs_fall;

  logic start_frame;
  logic end_frame;
  logic bit_rise;
  logic bit_fall;
  logic miso_c;

  logic word_done;
  logic copy_req;
  logic load_ok;

  logic [reg_width-1:0] tx_shift;
  logic [reg_width-1:0] hold;
  logic                 tx_ready_q;
  logic                 skip_fall;

  logic [reg_width-1:0] rx_shift;
  logic [reg_width-1:0] rx_next;
  logic [cnt_w-1:0]     bit_cnt;
  logic [reg_width-1:0] data_out_q;
  logic [cnt_w-1:0]     rx_bits_q;
  logic                 rx_valid_q;

  // Bring the asynchronous SPI pins into sys_clk, plus one extra copy for edge detect.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sclk_pipe <= '0;
      cs_pipe   <= '0;
      mosi_pipe <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_pipe <= {sclk_pipe[sync_stages-2:0], bus.spi_clk};
      cs_pipe   <= {cs_pipe[sync_stages-2:0], bus.cs};
      mosi_pipe <= {mosi_pipe[sync_stages-2:0], bus.mosi};
      sclk_d    <= sclk_pipe[sync_stages-1];
      cs_d      <= cs_pipe[sync_stages-1];
    end
  end

  assign sclk_s    = sclk_pipe[sync_stages-1];
  assign cs_s      = cs_pipe[sync_stages-1];
  assign mosi_s    = mosi_pipe[sync_stages-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  // State register.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state <= WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode from synchronized cs.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT:    if (cs_s)    state_nxt = IDLE;
      IDLE:    if (cs_fall) state_nxt = ACTIVE;
      ACTIVE:  if (cs_rise) state_nxt = IDLE;
      default: state_nxt = WAIT;
    endcase
  end

  // Per-state strobes and miso; a cs rise masks any spi_clk edge in the same cycle.
  always_comb begin
    start_frame = 1'b0;
    end_frame   = 1'b0;
    bit_rise    = 1'b0;
    bit_fall    = 1'b0;
    miso_c      = 1'b0;
    case (state)
      IDLE: begin
        start_frame = cs_fall;
      end
      ACTIVE: begin
        end_frame = cs_rise;
        bit_rise  = sclk_rise & ~cs_rise;
        bit_fall  = sclk_fall & ~cs_rise;
        miso_c    = tx_shift[reg_width-1];
      end
      default: ;
    endcase
  end

  assign word_done = bit_rise & (bit_cnt == last_cnt);
  assign copy_req  = start_frame | word_done;
  assign load_ok   = bus.tx_load & tx_ready_q;
  assign rx_next   = {rx_shift[reg_width-2:0], mosi_s};

  // Transmit side: holding register handshake, word reload and falling-edge shift.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      tx_shift   <= '0;
      hold       <= '0;
      tx_ready_q <= 1'b1;
      skip_fall  <= 1'b0;
    end else begin
      if (copy_req) begin
        // A load arriving in the copy cycle goes straight to the shifter,
        // so the holding register stays empty.
        if (!tx_ready_q) begin
          tx_shift <= hold;
        end else if (bus.tx_load) begin
          tx_shift <= bus.tx_data;
        end else begin
          tx_shift <= '0;
        end
        hold       <= '0;
        tx_ready_q <= 1'b1;
      end else begin
        if (load_ok) begin
          hold       <= bus.tx_data;
          tx_ready_q <= 1'b0;
        end
        if (bit_fall && !skip_fall) begin
          tx_shift <= {tx_shift[reg_width-2:0], 1'b0};
        end
      end

      // The falling edge right after a word reload must leave the new MSB on miso.
      if (copy_req) begin
        skip_fall <= word_done;
      end else if (bit_fall || end_frame) begin
        skip_fall <= 1'b0;
      end
    end
  end

  // Receive side: rising-edge capture, word/partial-word reporting.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rx_shift   <= '0;
      bit_cnt    <= '0;
      data_out_q <= '0;
      rx_bits_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (start_frame) begin
        rx_shift <= '0;
        bit_cnt  <= '0;
      end else if (end_frame) begin
        if (bit_cnt != '0) begin
          data_out_q <= rx_shift;
          rx_bits_q  <= bit_cnt;
          rx_valid_q <= 1'b1;
        end
      end else if (bit_rise) begin
        if (word_done) begin
          // Clear so a trailing partial word comes out right-justified with zero upper bits.
          rx_shift   <= '0;
          data_out_q <= rx_next;
          rx_bits_q  <= full_cnt;
          rx_valid_q <= 1'b1;
          bit_cnt    <= '0;
        end else begin
          rx_shift <= rx_next;
          bit_cnt  <= bit_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.miso     = miso_c;
  assign bus.tx_ready = tx_ready_q;
  assign bus.data_out = data_out_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_bits  = rx_bits_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural SPI master drives frames with
// hand-computed expected miso/data_out/rx_bits values.
module tb_spi_slave;
  localparam int RW = 16;
  localparam int CW = 5;

  logic sys_clk = 1'b0;
  logic rst;
  int   tests  = 0;
  int   fails  = 0;
  int   pulses = 0;
  int   p0;
  logic [RW-1:0] rx_log [0:7];
  logic [31:0]   mbits;

  spi_slave_if #(.reg_width(RW), .cnt_w(CW)) bus ();

  spi_slave #(.reg_width(RW), .sync_stages(2), .cnt_w(CW)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // Every high cycle of rx_valid counts, so a stretched pulse shows up as extra pulses.
  always @(negedge sys_clk) begin
    if (bus.rx_valid === 1'b1) begin
      rx_log[pulses % 8] <= bus.data_out;
      pulses             <= pulses + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_tx(input logic [RW-1:0] val);
    bus.tx_data = val;
    bus.tx_load = 1'b1;
    tick(1);
    bus.tx_load = 1'b0;
    tick(2);
  endtask

  // One cs assertion of nbits; optional tx_load or reset at the start of bit load_at/rst_at.
  task automatic frame(input logic [31:0] word, input int nbits, input int load_at,
                       input logic [RW-1:0] load_val, input int rst_at);
    mbits  = '0;
    bus.cs = 1'b0;
    tick(8);
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = word[nbits-1-i];
      if (i == rst_at) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("miso_after_rst", {31'd0, bus.miso}, 32'd0);
        tick(7);
      end else if (i == load_at) begin
        bus.tx_data = load_val;
        bus.tx_load = 1'b1;
        tick(1);
        bus.tx_load = 1'b0;
        tick(7);
      end else begin
        tick(8);
      end
      mbits = {mbits[30:0], bus.miso};
      bus.spi_clk = 1'b1;
      tick(8);
      bus.spi_clk = 1'b0;
    end
    tick(8);
    bus.cs = 1'b1;
    tick(12);
  endtask

  initial begin
    rst         = 1'b1;
    bus.cs      = 1'b1;
    bus.spi_clk = 1'b0;
    bus.mosi    = 1'b0;
    bus.tx_load = 1'b0;
    bus.tx_data = '0;
    tick(4);
    check("rst_miso",     {31'd0, bus.miso},     32'd0);
    check("rst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
    check("rst_data_out", {16'd0, bus.data_out}, 32'd0);
    check("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("rst_rx_bits",  {27'd0, bus.rx_bits},  32'd0);
    rst = 1'b0;
    tick(10);

    // Full 16-bit frame with a preloaded word.
    load_tx(16'hA5C3);
    check("t1_ready_low", {31'd0, bus.tx_ready}, 32'd0);
    p0 = pulses;
    frame(32'h0000_00EE, 16, -1, '0, -1);
    check("t1_miso",     mbits, 32'h0000_A5C3);
    check("t1_pulses",   pulses - p0, 32'd1);
    check("t1_data_out", {16'd0, bus.data_out}, 32'h0000_00EE);
    check("t1_rx_bits",  {27'd0, bus.rx_bits},  32'd16);
    check("t1_ready",    {31'd0, bus.tx_ready}, 32'd1);
    check("t1_valid_lo", {31'd0, bus.rx_valid}, 32'd0);

    // Partial 8-bit word, nothing loaded.
    p0 = pulses;
    frame(32'h0000_00A7, 8, -1, '0, -1);
    check("t2_miso",     mbits, 32'h0000_0000);
    check("t2_pulses",   pulses - p0, 32'd1);
    check("t2_data_out", {16'd0, bus.data_out}, 32'h0000_00A7);
    check("t2_rx_bits",  {27'd0, bus.rx_bits},  32'd8);

    // Empty holding register: miso stays low.
    p0 = pulses;
    frame(32'h0000_FFFF, 16, -1, '0, -1);
    check("t3_miso",     mbits, 32'h0000_0000);
    check("t3_pulses",   pulses - p0, 32'd1);
    check("t3_data_out", {16'd0, bus.data_out}, 32'h0000_FFFF);

    // Two back-to-back words; second tx word loaded during the first.
    load_tx(16'h0F0F);
    p0 = pulses;
    frame(32'h1234_BEEF, 32, 4, 16'hF0F0, -1);
    check("t4_miso",     mbits, 32'h0F0F_F0F0);
    check("t4_pulses",   pulses - p0, 32'd2);
    check("t4_word0",    {16'd0, rx_log[p0 % 8]},       32'h0000_1234);
    check("t4_word1",    {16'd0, rx_log[(p0 + 1) % 8]}, 32'h0000_BEEF);
    check("t4_rx_bits",  {27'd0, bus.rx_bits},  32'd16);
    check("t4_ready",    {31'd0, bus.tx_ready}, 32'd1);

    // Second load while full is dropped.
    load_tx(16'h1111);
    check("t5_ready_lo", {31'd0, bus.tx_ready}, 32'd0);
    load_tx(16'h2222);
    check("t5_ready_lo2", {31'd0, bus.tx_ready}, 32'd0);
    p0 = pulses;
    frame(32'h0000_0000, 16, -1, '0, -1);
    check("t5_miso",     mbits, 32'h0000_1111);
    check("t5_pulses",   pulses - p0, 32'd1);
    check("t5_data_out", {16'd0, bus.data_out}, 32'h0000_0000);

    // Reset after 5 bits: frame abandoned, miso low from then on.
    load_tx(16'hFFFF);
    p0 = pulses;
    frame(32'h0000_ABCD, 16, -1, '0, 5);
    check("t6_miso",     mbits, 32'h0000_F800);
    check("t6_pulses",   pulses - p0, 32'd0);
    check("t6_data_out", {16'd0, bus.data_out}, 32'h0000_0000);
    check("t6_rx_bits",  {27'd0, bus.rx_bits},  32'd0);
    check("t6_ready",    {31'd0, bus.tx_ready}, 32'd1);

    // Recovery frame after the aborted one.
    p0 = pulses;
    frame(32'h0000_C001, 16, -1, '0, -1);
    check("t7_miso",     mbits, 32'h0000_0000);
    check("t7_pulses",   pulses - p0, 32'd1);
    check("t7_data_out", {16'd0, bus.data_out}, 32'h0000_C001);
    check("t7_rx_bits",  {27'd0, bus.rx_bits},  32'd16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
